// File: rtl/skid_buffer_arstn.sv
// skid_buffer_arstn: two-entry valid/ready pipeline slice with asynchronous active-low reset.
//
// Registers both the forward path (valid/data) and the backward path (ready) so that a long
// streaming link can be cut without losing throughput. A second "skid" register absorbs the
// beat that arrives in the cycle where the consumer stalls but s_ready has not yet dropped.
//
// Optional build macro: SKID_BUFFER_STALL_CNT_EN adds a saturating stall counter (stall_cnt).
//
// Parameters:
//   WIDTH      payload width in bits (>= 1)
//   CNT_WIDTH  stall counter width (>= 1), used only with SKID_BUFFER_STALL_CNT_EN
//
// Ports:
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   s_valid    producer data valid
//   s_ready    block can accept (flop output)
//   s_data     producer payload
//   m_valid    output payload valid (flop output)
//   m_ready    consumer accepts
//   m_data     output payload (flop output)
//   stall_cnt  cycles with m_valid=1 and m_ready=0, saturating (macro builds only)

module skid_buffer_arstn #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef SKID_BUFFER_STALL_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_xfer) begin
          data_d  = s_data;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (in_xfer && out_xfer) begin
          data_d = s_data;
        end else if (out_xfer) begin
          state_d = StEmpty;
        end else if (in_xfer) begin
          // Consumer stalled while s_ready was still high: park the beat.
          skid_d  = s_data;
          state_d = StFull;
        end
      end
      StFull: begin
        // s_ready is low here, so no new beat can arrive; drain skid first.
        if (m_ready) begin
          data_d  = skid_q;
          state_d = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Handshake flops are loaded from the next state so outputs stay pure flop outputs.
    s_ready_d = (state_d != StFull);
    m_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StEmpty;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      data_q    <= '0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      data_q    <= data_d;
      skid_q    <= skid_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = data_q;

`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
    end else if (m_valid_q && !m_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/skid_buffer_arstn.md
Name: skid_buffer_arstn

Overview:
- Two-entry valid/ready pipeline slice; breaks both the forward path (valid/data) and the backward path (ready) with flops.
- Complements the plain data register: the plain register only carries data forward; this block also registers the reverse backpressure direction without losing throughput.
- Inserted on long streaming paths between producer (s_*) and consumer (m_*).

Parameters:
- WIDTH, 8, payload width in bits (>=1)
- CNT_WIDTH, 16, stall counter width; used only when SKID_BUFFER_STALL_CNT_EN is defined (>=1)

Ports:
- clk  input  1  single clock, rising edge
- rstn  input  1  asynchronous active-low reset
- s_valid  input  1  producer data valid
- s_ready  output  1  block can accept; driven directly from a flop
- s_data  input  WIDTH  producer payload
- m_valid  output  1  output payload valid; driven directly from a flop
- m_ready  input  1  consumer accepts
- m_data  output  WIDTH  output payload; driven directly from a flop
- stall_cnt  output  CNT_WIDTH  present only with SKID_BUFFER_STALL_CNT_EN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstn). All flops clear immediately on rstn low, independent of clk.
- Reset values:
  - s_ready=0, m_valid=0, m_data=0
  - skid register=0, stall_cnt=0
  - state=EMPTY
- s_ready rises on the first clk edge after rstn deasserts.
- Transfers:
  - Input transfer = s_valid&s_ready at a clk edge.
  - Output transfer = m_valid&m_ready at a clk edge.
  - Latency from input transfer to m_valid high: 1 cycle.
- States:
  - EMPTY: m_valid=0, next s_ready=1.
  - BUSY: output register holds one beat, skid register empty; m_valid=1, s_ready=1.
  - FULL: both registers hold beats; m_valid=1, s_ready=0.
- Transitions:
  - EMPTY, input transfer -> m_data<=s_data; go to BUSY.
  - BUSY, input and output transfer -> m_data<=s_data; stay BUSY (full throughput, 1 beat/cycle).
  - BUSY, output transfer only -> EMPTY.
  - BUSY, input transfer only -> skid<=s_data; go to FULL; s_ready drops next cycle.
  - FULL, m_ready=1 -> m_data<=skid; go to BUSY; s_ready returns to 1 next cycle.
  - FULL, m_ready=0 -> hold.
  - Any state with no event -> hold all registers.
- Ordering: strict FIFO. The skid beat is always output before any later input.
- Input while s_ready=0: ignored. The producer must hold s_valid and s_data; the block never drops or duplicates a beat.
- Once asserted, m_valid stays high with m_data stable until an output transfer.
- Reset mid-operation: beats held in the output and skid registers are discarded; no partial output.
- s_ready must not depend combinationally on m_ready, and m_valid must not depend combinationally on s_valid. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: SKID_BUFFER_STALL_CNT_EN
- When defined:
  - Adds output port stall_cnt[CNT_WIDTH-1:0].
  - Increments by 1 on every clk edge where m_valid=1 and m_ready=0.
  - Saturates at all-ones; does not wrap.
  - Cleared only by rstn.
- When undefined:
  - Port and counter logic are absent.
  - Datapath behaviour is identical in both builds.

Test Plan:
- Reset: hold rstn=0 with s_valid=1 -> s_ready=0, m_valid=0, m_data=0. Release rstn -> s_ready=1 after 1 clk.
- Streaming: m_ready=1, s_valid=1, s_data=0x01..0x10 on consecutive cycles -> m_data=0x01..0x10 one cycle later, no bubbles, s_ready stays 1.
- Backpressure: send 0xA1,0xA2 with m_ready=0 -> FULL, s_ready=0. Drive 0xA3 on s_data -> not accepted. Raise m_ready -> outputs 0xA1,0xA2,0xA3 in order.
- Random: random s_valid/m_ready at 50% for 10000 cycles -> output sequence equals input sequence exactly. Scoreboard checks no loss or duplication, and m_data is stable while m_valid&~m_ready.
- Async reset in FULL: assert rstn between edges -> m_valid and s_ready go 0 immediately. After release, the next beat 0x55 emerges alone.
- SKID_BUFFER_STALL_CNT_EN, CNT_WIDTH=4: hold m_valid=1, m_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Without the macro -> port absent; the streaming test still passes.
